// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: memory-side front end of the 16-bit core.
// Owns the single block-RAM port. It fetches instructions into the IR and
// performs data loads and stores. The IR fields are exposed as plain wires.
//
// Handshake: a request (fetchStart or dataReq) is sampled only while
// busy=0. dataReq has priority over fetchStart. A request seen while busy=1
// is dropped, not queued. Completion is signalled by a one-cycle pulse:
// instrValid for a fetch, dataDone for a load or store.
module fetch_mem_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [15:0] dataAddr,
    input  logic [15:0] storeData,
    input  logic        fetchStart,
    input  logic        dataReq,
    input  logic        dataWrite,
    input  logic [15:0] memRdata,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    output logic        memWe,
    output logic [15:0] instruction,
    output logic [7:0]  instructionOp,
    output logic [3:0]  regAddB,
    output logic [3:0]  regAddA,
    output logic [7:0]  immediate,
    output logic        instrValid,
    output logic [15:0] loadData,
    output logic        dataDone,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FWAIT = 3'd2,
        ST_DATA  = 3'd3,
        ST_DWAIT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;      // latched pc or dataAddr
    logic [15:0] wdata_q, wdata_d;    // latched store value
    logic        write_q, write_d;    // latched access direction
    logic [15:0] ir_q, ir_d;
    logic [15:0] load_q, load_d;
    logic        instr_valid_q, instr_valid_d;
    logic        data_done_q, data_done_d;

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= 16'h0000;
            wdata_q       <= 16'h0000;
            write_q       <= 1'b0;
            ir_q          <= 16'h0000;
            load_q        <= 16'h0000;
            instr_valid_q <= 1'b0;
            data_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            ir_q          <= ir_d;
            load_q        <= load_d;
            instr_valid_q <= instr_valid_d;
            data_done_q   <= data_done_d;
        end
    end

    // Next-state logic, request latching and completion pulses.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        ir_d          = ir_q;
        load_d        = load_q;
        instr_valid_d = 1'b0;
        data_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dataReq) begin
                    addr_d  = dataAddr;
                    wdata_d = storeData;
                    write_d = dataWrite;
                    state_d = ST_DATA;
                end else if (fetchStart) begin
                    addr_d  = pc;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_FWAIT;
            ST_FWAIT: begin
                ir_d          = memRdata;
                instr_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_DATA: begin
                if (write_q) begin
                    data_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DWAIT;
                end
            end
            ST_DWAIT: begin
                load_d      = memRdata;
                data_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port decode. These are purely combinational from state, so an
    // asynchronous reset drops memWe without waiting for a clock edge.
    always_comb begin
        memAddr  = pc;
        memWdata = 16'h0000;
        memWe    = 1'b0;
        case (state_q)
            ST_FETCH, ST_FWAIT, ST_DWAIT: memAddr = addr_q;
            ST_DATA: begin
                memAddr = addr_q;
                if (write_q) begin
                    memWdata = wdata_q;
                    memWe    = 1'b1;
                end
            end
            default: memAddr = pc;
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign instruction   = ir_q;
    assign instructionOp = {ir_q[15:12], ir_q[7:4]};
    assign regAddB       = ir_q[11:8];
    assign regAddA       = ir_q[3:0];
    assign immediate     = ir_q[7:0];
    assign instrValid    = instr_valid_q;
    assign loadData      = load_q;
    assign dataDone      = data_done_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Bench for fetch_mem_unit: a synchronous 64K x 16 RAM model, directed
// stimulus and an expected-value queue per completion pulse.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc, dataAddr, storeData;
    logic        fetchStart, dataReq, dataWrite;
    logic [15:0] memRdata;
    logic [15:0] memAddr, memWdata;
    logic        memWe;
    logic [15:0] instruction;
    logic [7:0]  instructionOp;
    logic [3:0]  regAddB, regAddA;
    logic [7:0]  immediate;
    logic        instrValid;
    logic [15:0] loadData;
    logic        dataDone;
    logic        busy;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_ir_q[$];
    logic [15:0] exp_ld_q[$];
    logic [15:0] model_ir;
    logic [15:0] model_ld;
    int          total = 0;
    int          bad = 0;

    fetch_mem_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .dataAddr(dataAddr),
        .storeData(storeData), .fetchStart(fetchStart), .dataReq(dataReq),
        .dataWrite(dataWrite), .memRdata(memRdata), .memAddr(memAddr),
        .memWdata(memWdata), .memWe(memWe), .instruction(instruction),
        .instructionOp(instructionOp), .regAddB(regAddB), .regAddA(regAddA),
        .immediate(immediate), .instrValid(instrValid), .loadData(loadData),
        .dataDone(dataDone), .busy(busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Synchronous RAM: read-before-write, data valid the cycle after address.
    always @(posedge clk) begin
        memRdata <= mem[memAddr];
        if (memWe === 1'b1) mem[memAddr] = memWdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge and score any pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (instrValid === 1'b1) begin
            chk("busy_with_instrValid", busy, 0);
            if (exp_ir_q.size() == 0) chk("unexpected_instrValid", 1, 0);
            else chk("ir_on_pulse", instruction, exp_ir_q.pop_front());
        end
        if (dataDone === 1'b1) begin
            chk("busy_with_dataDone", busy, 0);
            if (exp_ld_q.size() == 0) chk("unexpected_dataDone", 1, 0);
            else chk("loadData_on_pulse", loadData, exp_ld_q.pop_front());
        end
    endtask

    // Fetch at a; returns in the instrValid cycle.
    task automatic fetch_op(input logic [15:0] a);
        logic [15:0] e;
        e = mem[a];
        pc = a;
        fetchStart = 1'b1;
        exp_ir_q.push_back(e);
        tick();
        fetchStart = 1'b0;
        pc = ~a;
        chk("fetch_busy", busy, 1);
        chk("fetch_memAddr", memAddr, a);
        chk("fetch_memWe", memWe, 0);
        chk("fetch_iv_early", instrValid, 0);
        tick();
        chk("fwait_busy", busy, 1);
        chk("fwait_iv_early", instrValid, 0);
        tick();
        chk("fetch_instrValid", instrValid, 1);
        chk("fetch_ir", instruction, e);
        chk("fetch_loadData_kept", loadData, model_ld);
        model_ir = e;
    endtask

    // Load from a; returns in the dataDone cycle.
    task automatic load_op(input logic [15:0] a);
        logic [15:0] e;
        e = mem[a];
        dataAddr = a;
        dataWrite = 1'b0;
        dataReq = 1'b1;
        exp_ld_q.push_back(e);
        tick();
        dataReq = 1'b0;
        fetchStart = 1'b0;
        dataAddr = ~a;
        chk("load_busy", busy, 1);
        chk("load_memAddr", memAddr, a);
        chk("load_memWe", memWe, 0);
        tick();
        chk("dwait_busy", busy, 1);
        chk("dwait_done_early", dataDone, 0);
        tick();
        chk("load_dataDone", dataDone, 1);
        chk("load_value", loadData, e);
        chk("load_ir_kept", instruction, model_ir);
        model_ld = e;
    endtask

    // Store d to a; returns in the dataDone cycle.
    task automatic store_op(input logic [15:0] a, input logic [15:0] d);
        dataAddr = a;
        storeData = d;
        dataWrite = 1'b1;
        dataReq = 1'b1;
        exp_ld_q.push_back(model_ld);
        tick();
        dataReq = 1'b0;
        dataAddr = ~a;
        storeData = ~d;
        chk("store_memWe", memWe, 1);
        chk("store_memAddr", memAddr, a);
        chk("store_memWdata", memWdata, d);
        chk("store_busy", busy, 1);
        chk("store_done_early", dataDone, 0);
        tick();
        chk("store_memWe_single", memWe, 0);
        chk("store_dataDone", dataDone, 1);
        chk("store_ir_kept", instruction, model_ir);
        chk("store_loadData_kept", loadData, model_ld);
    endtask

    // Directed test sequence.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C5A;
        mem[16'h0000] = 16'h7E21;
        mem[16'h0001] = 16'h2B9F;
        mem[16'h0004] = 16'h5A13;
        mem[16'h0010] = 16'hC0DE;
        mem[16'h0020] = 16'h1234;
        mem[16'h0200] = 16'h0F0F;
        mem[16'hFFFF] = 16'h8001;
        model_ir = 16'h0000;
        model_ld = 16'h0000;
        reset = 1'b1;
        pc = 16'h0000;
        dataAddr = 16'h0000;
        storeData = 16'h0000;
        fetchStart = 1'b0;
        dataReq = 1'b0;
        dataWrite = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_instruction", instruction, 16'h0000);
        chk("rst_loadData", loadData, 16'h0000);
        chk("rst_instrValid", instrValid, 0);
        chk("rst_dataDone", dataDone, 0);
        chk("rst_busy", busy, 0);
        chk("rst_memWe", memWe, 0);
        chk("rst_memWdata", memWdata, 16'h0000);
        reset = 1'b0;
        tick();
        pc = 16'h0033;
        #1;
        chk("idle_memAddr_pc", memAddr, 16'h0033);

        // Basic fetch and field split.
        fetch_op(16'h0004);
        chk("op_field", instructionOp, 8'h51);
        chk("regB_field", regAddB, 4'hA);
        chk("regA_field", regAddA, 4'h3);
        chk("imm_field", immediate, 8'h13);
        tick();
        chk("iv_one_cycle", instrValid, 0);

        // Store then load back.
        store_op(16'h0100, 16'hBEEF);
        tick();
        chk("done_one_cycle", dataDone, 0);
        load_op(16'h0100);
        chk("readback", loadData, 16'hBEEF);
        tick();

        // fetchStart and dataReq together: load wins, fetch dropped.
        pc = 16'h0010;
        fetchStart = 1'b1;
        load_op(16'h0020);
        chk("both_loadData", loadData, 16'h1234);
        chk("both_ir_kept", instruction, 16'h5A13);
        tick();
        tick();
        chk("both_no_fetch", busy, 0);
        fetch_op(16'h0010);

        // fetchStart held while busy: one fetch only.
        tick();
        pc = 16'h0000;
        fetchStart = 1'b1;
        exp_ir_q.push_back(mem[16'h0000]);
        tick();
        pc = 16'h0001;
        chk("busy_fetch_memAddr", memAddr, 16'h0000);
        tick();
        fetchStart = 1'b0;
        tick();
        chk("busy_fetch_iv", instrValid, 1);
        chk("busy_fetch_ir", instruction, 16'h7E21);
        model_ir = 16'h7E21;
        tick();
        tick();
        tick();
        chk("busy_fetch_idle", busy, 0);

        // Back-to-back fetches: one pulse every 3 cycles.
        fetch_op(16'h0000);
        fetch_op(16'h0001);
        chk("b2b_ir", instruction, 16'h2B9F);
        tick();

        // Reset during the store's DATA cycle.
        dataAddr = 16'h0200;
        storeData = 16'h1111;
        dataWrite = 1'b1;
        dataReq = 1'b1;
        tick();
        dataReq = 1'b0;
        dataWrite = 1'b0;
        chk("abort_memWe_before", memWe, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_memWe_drop", memWe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ir", instruction, 16'h0000);
        chk("abort_loadData", loadData, 16'h0000);
        chk("abort_memWdata", memWdata, 16'h0000);
        model_ir = 16'h0000;
        model_ld = 16'h0000;
        tick();
        chk("abort_no_done", dataDone, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("abort_no_done_later", dataDone, 0);
        load_op(16'h0200);
        chk("abort_no_write", loadData, 16'h0F0F);
        tick();

        // Top-of-memory fetch.
        fetch_op(16'hFFFF);
        chk("top_ir", instruction, 16'h8001);
        chk("top_op", instructionOp, 8'h80);
        chk("top_regB", regAddB, 4'h0);
        chk("top_regA", regAddA, 4'h1);
        tick();
        tick();

        chk("ir_queue_empty", exp_ir_q.size(), 0);
        chk("ld_queue_empty", exp_ld_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
